// File: rtl/program_loader_pkg.sv
// Shared processor definitions: loader state encoding, width defaults and the
// per-state control-output map used by the loader and the control unit.
package program_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    // Length field carried in the low bits of the first stream word.
    localparam int LEN_W      = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    typedef struct packed {
        logic word_ready;
        logic cpu_reset;
        logic cpu_start;
        logic busy;
        logic error;
    } ctl_t;

    function automatic ctl_t ctl_for(state_t s);
        ctl_t c;
        c.word_ready = (s == S_LEN) || (s == S_LOAD);
        c.cpu_reset  = (s != S_RUN);
        c.cpu_start  = (s == S_START) || (s == S_RUN);
        c.busy       = (s == S_LEN) || (s == S_LOAD) || (s == S_START) || (s == S_RUN);
        c.error      = (s == S_ERR);
        return c;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams a length-prefixed program into instruction memory, then starts the
// processor and supervises its run with a timeout.
//
//   state | meaning
//   IDLE  | waiting for load_req, processor held in reset
//   LEN   | waiting for the length word
//   LOAD  | writing instruction words into IM
//   START | one-cycle start pulse with processor still in reset
//   RUN   | processor running, run counter advancing
//   DONE  | processor finished, held quiescent
//   ERR   | bad length or run timeout, error flag raised
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RUN_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word_data,
    output logic              word_ready,
    output logic              im_en_write,
    output logic [ADDR_W-1:0] im_address,
    output logic [DATA_W-1:0] im_data,
    output logic              cpu_reset,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic              busy,
    output logic              error
);

    localparam int RUN_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_TIMEOUT - 1);
    localparam int MAX_N = 2 ** ADDR_W;

    state_t            state;
    ctl_t              ctl;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [RUN_W-1:0]  run_cnt;
    logic [LEN_W-1:0]  len;
    logic              len_bad;
    logic              accept;

    assign len     = word_data[LEN_W-1:0];
    assign len_bad = (len == '0) || (int'(len) > MAX_N);
    assign accept  = word_valid && ctl.word_ready;

    assign word_ready = ctl.word_ready;
    assign cpu_reset  = ctl.cpu_reset;
    assign cpu_start  = ctl.cpu_start;
    assign busy       = ctl.busy;
    assign error      = ctl.error;

    // Control outputs are loaded with the value of the state being entered,
    // so they are registered and aligned with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ctl         <= ctl_for(S_IDLE);
            im_en_write <= 1'b0;
            im_address  <= '0;
            im_data     <= '0;
            addr_cnt    <= '0;
            last_addr   <= '0;
            run_cnt     <= '0;
        end else begin
            im_en_write <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_req) begin
                        state <= S_LEN;
                        ctl   <= ctl_for(S_LEN);
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            state <= S_ERR;
                            ctl   <= ctl_for(S_ERR);
                        end else begin
                            addr_cnt  <= '0;
                            last_addr <= ADDR_W'(len - LEN_W'(1));
                            state     <= S_LOAD;
                            ctl       <= ctl_for(S_LOAD);
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        im_en_write <= 1'b1;
                        im_address  <= addr_cnt;
                        im_data     <= word_data;
                        addr_cnt    <= addr_cnt + ADDR_W'(1);
                        if (addr_cnt == last_addr) begin
                            state <= S_START;
                            ctl   <= ctl_for(S_START);
                        end
                    end
                end
                S_START: begin
                    run_cnt <= '0;
                    state   <= S_RUN;
                    ctl     <= ctl_for(S_RUN);
                end
                S_RUN: begin
                    // An explicit reload aborts the run; completion beats timeout.
                    if (load_req) begin
                        state <= S_LEN;
                        ctl   <= ctl_for(S_LEN);
                    end else if (cpu_done) begin
                        state <= S_DONE;
                        ctl   <= ctl_for(S_DONE);
                    end else if (run_cnt == RUN_LAST) begin
                        state <= S_ERR;
                        ctl   <= ctl_for(S_ERR);
                    end else begin
                        run_cnt <= run_cnt + RUN_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ctl   <= ctl_for(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameters: ADDR_W default 10, instruction-address width; DATA_W default 16, instruction width; RUN_TIMEOUT default 4096, maximum run cycles before abort.
REQ-002 SHALL have ports: clk  in  1  single system clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 load_req  in  1  one-cycle request to start a new program load.
REQ-005 word_valid  in  1  word_data is valid this cycle.
REQ-006 word_data  in  DATA_W  stream word: first word is length N, then N instruction words.
REQ-007 word_ready  out  1  loader accepts a word this cycle.
REQ-008 im_en_write  out  1  instruction-memory write enable.
REQ-009 im_address  out  ADDR_W  instruction-memory write address.
REQ-010 im_data  out  DATA_W  instruction-memory write data.
REQ-011 cpu_reset  out  1  processor reset.
REQ-012 cpu_start  out  1  processor start.
REQ-013 cpu_done  in  1  processor finished execution.
REQ-014 busy  out  1  high in LEN, LOAD, START and RUN.
REQ-015 error  out  1  sticky error flag, cleared by the next accepted load_req.

Function
REQ-016 SHALL implement an FSM with states IDLE, LEN, LOAD, START, RUN, DONE and ERR; all outputs SHALL be registered.
REQ-017 Transfer rule: a word SHALL be accepted only on a clock edge where word_valid=1 and word_ready=1; word_ready SHALL be 1 only in LEN and LOAD.
REQ-018 IDLE/DONE/ERR -> LEN on load_req=1; error SHALL clear and cpu_reset SHALL be 1 from the next cycle.
REQ-019 LEN: the accepted word[10:0] SHALL be N. If N=0 or N>2^ADDR_W, go to ERR. Otherwise, write address counter := 0 and go to LOAD.
REQ-020 LOAD: each accepted word SHALL produce exactly one im_en_write=1 cycle on the following cycle, with im_address equal to the counter and im_data equal to the word; the counter SHALL then increment.
REQ-021 In LOAD, the Nth accepted word SHALL move the FSM to START; stalls (word_valid=0) SHALL leave the counter and state unchanged.
REQ-022 START SHALL last exactly 1 cycle with cpu_reset=1 and cpu_start=1, then go to RUN.
REQ-023 RUN: cpu_reset=0 and cpu_start=1; the run counter SHALL increment each cycle.
REQ-024 In RUN, cpu_done=1 SHALL move the FSM to DONE; otherwise, the run counter reaching RUN_TIMEOUT-1 SHALL move it to ERR. If both occur in the same cycle, cpu_done SHALL win.
REQ-025 DONE: cpu_start=0 and cpu_reset=1, holding the processor quiescent.
REQ-026 ERR: error=1, cpu_start=0 and cpu_reset=1.
REQ-027 load_req during LEN/LOAD/START SHALL be ignored; load_req during RUN SHALL abort the run and go to LEN, with cpu_reset=1 on the next cycle.
REQ-028 im_en_write SHALL be 0 in every state except the cycle following a LOAD acceptance; the address SHALL never wrap within one load.

Reset
REQ-029 On reset=1 at a clock edge, the FSM SHALL go to IDLE, regardless of state, including mid-load or mid-run.
REQ-030 Reset values SHALL be: word_ready=0, im_en_write=0, im_address=0, im_data=0, cpu_reset=1, cpu_start=0, busy=0, error=0, both counters 0.
REQ-031 A load interrupted by reset SHALL NOT resume; partial IM contents SHALL be left as written.

Structure
REQ-032 The state encoding and the ADDR_W/DATA_W defaults SHALL live in a shared processor package, also used by the control unit.
REQ-033 The FSM and the address/run counters SHALL be in one module; no sub-module is required.

Verification
REQ-034 Load N=3 (0x4203, 0x4001, 0x6800), word_valid always 1 -> im writes at addresses 0,1,2 on consecutive cycles; START 1 cycle; RUN with cpu_reset=0.
REQ-035 Same stream with word_valid toggling 1/0 -> identical writes, one per accepted word; counter holds during gaps.
REQ-036 Length word 0x0000, then separately 0x0401 (N=1025) -> ERR, error=1, no im_en_write pulse.
REQ-037 In RUN, cpu_done=1 on cycle 5 -> DONE next cycle, cpu_start=0, cpu_reset=1; with RUN_TIMEOUT=8 and no done -> ERR after 8 RUN cycles.
REQ-038 reset=1 after 2 of 3 words loaded -> IDLE, all outputs at reset values next cycle; a new load_req then restarts at address 0.
REQ-039 load_req during RUN -> cpu_reset=1 next cycle, state LEN, error cleared.
